// File: rtl/led_pattern_writer.sv
// Purpose : write side of the LED pattern memory. It accepts a session of patterns over a
//           valid/ready handshake, stores them in a DEPTH-entry RAM and commits the session
//           length so the playback logic knows how many entries are valid.
// Latency : a beat is written on its handshake edge. count, done and overflow update on the
//           commit edge, so done is seen high the cycle after the final beat. rd_data lags
//           rd_addr by one cycle.
// Backpressure: in_ready is high only while a session is open (LOAD). It drops as soon as
//           the session commits, so extra beats stay with the source.
// Optional: define LED_PATTERN_WRITER_CHECKSUM_EN to add the checksum output, which is the
//           XOR of all patterns in the last committed session.
// Ports   : CLK/RESET (synchronous, active-high); start opens or restarts a session;
//           in_valid/in_data/in_last/in_ready carry the pattern stream; rd_addr/rd_data form
//           the registered playback read port; count, busy, done and overflow report status.
module led_pattern_writer #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             busy,
  output logic             done,
  output logic             overflow
`ifdef LED_PATTERN_WRITER_CHECKSUM_EN
  ,
  output logic [WIDTH-1:0] checksum
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             done_q, done_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  logic [WIDTH-1:0] ram_q [DEPTH];

  logic accept;
  logic at_end;
  logic commit;

  // Handshake and commit decode.
  // A start in LOAD overrides a commit beat. The beat is still written at the old address,
  // but the restart discards the session, so nothing else may be committed.
  always_comb begin
    accept = in_valid && in_ready;
    at_end = (wr_ptr_q == AW'(DEPTH - 1));
    commit = (state_q == LOAD) && accept && !start && (in_last || at_end);
  end

  // FSM: state register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (start) begin
          state_d = LOAD;
        end else if (commit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. in_ready is combinational from state so it is valid in the same cycle.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    if (state_q == LOAD) begin
      in_ready = 1'b1;
      busy     = 1'b1;
    end
  end

  // Session datapath next-state logic.
  // wr_ptr holds at DEPTH-1 on the commit beat instead of advancing. It therefore never wraps,
  // and the next start clears it.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    done_d     = commit;

    if (start) begin
      wr_ptr_d   = '0;
      overflow_d = 1'b0;
    end else if (commit) begin
      count_d    = (AW+1)'(wr_ptr_q) + (AW+1)'(1);
      overflow_d = at_end && !in_last;
    end else if (accept) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q   <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  // Pattern RAM. Its contents survive reset; count=0 already marks the table as empty.
  always_ff @(posedge CLK) begin
    if (accept) begin
      ram_q[wr_ptr_q] <= in_data;
    end
  end

  // Registered read port. The array is sampled before this edge's write lands, so a
  // read and a write to the same address in one cycle return the old data.
  always_comb begin
    rd_data_d = ram_q[rd_addr];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign count    = count_q;
  assign done     = done_q;
  assign overflow = overflow_q;

`ifdef LED_PATTERN_WRITER_CHECKSUM_EN
  logic [WIDTH-1:0] xor_q, xor_d;
  logic [WIDTH-1:0] checksum_q, checksum_d;

  // The running XOR restarts with each session. The published checksum includes the
  // commit beat itself and updates on the same edge as count.
  always_comb begin
    xor_d      = xor_q;
    checksum_d = checksum_q;
    if (start) begin
      xor_d = '0;
    end else if (accept) begin
      xor_d = xor_q ^ in_data;
    end
    if (commit) begin
      checksum_d = xor_q ^ in_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      xor_q      <= '0;
      checksum_q <= '0;
    end else begin
      xor_q      <= xor_d;
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_led_pattern_writer.sv
module tb_led_pattern_writer;

  localparam int WIDTH = 5;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             CLK;
  logic             RESET;
  logic             start;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             in_ready;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic [AW:0]      count;
  logic             busy;
  logic             done;
  logic             overflow;
`ifdef LED_PATTERN_WRITER_CHECKSUM_EN
  logic [WIDTH-1:0] checksum;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  led_pattern_writer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
`ifdef LED_PATTERN_WRITER_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [WIDTH-1:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [WIDTH-1:0] exp);
    rd_addr = a;
    tick();
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic open_session();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [WIDTH-1:0] t2_data [4];

  initial begin
    t2_data[0] = 5'b00001;
    t2_data[1] = 5'b00010;
    t2_data[2] = 5'b00100;
    t2_data[3] = 5'b11111;

    RESET    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    rd_addr  = '0;

    // Reset held for two cycles.
    tick();
    tick();
    RESET = 1'b0;
    check("rst_count",    32'(count),    32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_rd_data",  32'(rd_data),  32'd0);
`ifdef LED_PATTERN_WRITER_CHECKSUM_EN
    check("rst_checksum", 32'(checksum), 32'd0);
`endif

    // Four-beat session terminated by in_last.
    open_session();
    check("s1_busy",     32'(busy),     32'd1);
    check("s1_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      beat(t2_data[i], i == 3);
      if (i < 3) check("s1_no_early_done", 32'(done), 32'd0);
    end
    check("s1_done",     32'(done),     32'd1);
    check("s1_count",    32'(count),    32'd4);
    check("s1_overflow", 32'(overflow), 32'd0);
    check("s1_idle",     32'(in_ready), 32'd0);
`ifdef LED_PATTERN_WRITER_CHECKSUM_EN
    check("s1_checksum", 32'(checksum), 32'h18);
`endif
    tick();
    check("s1_done_once", 32'(done), 32'd0);
    for (int a = 0; a < 4; a++) read_check("s1_read", AW'(a), t2_data[a]);

    // Sixteen beats without in_last: truncation at DEPTH.
    open_session();
    for (int i = 0; i < DEPTH; i++) begin
      beat(WIDTH'(i), 1'b0);
    end
    check("s2_done",     32'(done),     32'd1);
    check("s2_count",    32'(count),    32'd16);
    check("s2_overflow", 32'(overflow), 32'd1);
    check("s2_in_ready", 32'(in_ready), 32'd0);
    beat(5'h1f, 1'b0);   // 17th beat: nobody is listening
    check("s2_overflow_sticky", 32'(overflow), 32'd1);
    read_check("s2_addr0",  4'd0,  5'd0);
    read_check("s2_addr15", 4'd15, 5'd15);

    // Gapped valid: only handshake cycles write.
    open_session();
    beat(5'h0a, 1'b0);
    in_data = 5'h1f; tick();   // valid low, junk data
    beat(5'h15, 1'b0);
    in_data = 5'h1e; tick();
    beat(5'h07, 1'b1);
    check("s3_count",    32'(count),    32'd3);
    check("s3_done",     32'(done),     32'd1);
    check("s3_overflow", 32'(overflow), 32'd0);
`ifdef LED_PATTERN_WRITER_CHECKSUM_EN
    check("s3_checksum", 32'(checksum), 32'h18);
`endif
    read_check("s3_addr0", 4'd0, 5'h0a);
    read_check("s3_addr1", 4'd1, 5'h15);
    read_check("s3_addr2", 4'd2, 5'h07);

    // Restart mid-session. The restart beat also carries in_last, and start must win.
    open_session();
    beat(5'h11, 1'b0);
    beat(5'h12, 1'b0);
    start = 1'b1;
    beat(5'h13, 1'b1);
    start = 1'b0;
    check("s4_no_done_restart", 32'(done),  32'd0);
    check("s4_busy_restart",    32'(busy),  32'd1);
    check("s4_count_held",      32'(count), 32'd3);
    beat(5'h04, 1'b0);
    check("s4_no_done_mid", 32'(done), 32'd0);
    beat(5'h05, 1'b1);
    check("s4_done",  32'(done),  32'd1);
    check("s4_count", 32'(count), 32'd2);
`ifdef LED_PATTERN_WRITER_CHECKSUM_EN
    check("s4_checksum", 32'(checksum), 32'h01);
`endif
    read_check("s4_addr0", 4'd0, 5'h04);
    read_check("s4_addr1", 4'd1, 5'h05);

    // Reset in the middle of a session.
    open_session();
    beat(5'h09, 1'b0);
    beat(5'h0c, 1'b0);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("s5_rst_busy",     32'(busy),     32'd0);
    check("s5_rst_count",    32'(count),    32'd0);
    check("s5_rst_done",     32'(done),     32'd0);
    check("s5_rst_in_ready", 32'(in_ready), 32'd0);
`ifdef LED_PATTERN_WRITER_CHECKSUM_EN
    check("s5_rst_checksum", 32'(checksum), 32'd0);
`endif
    open_session();
    beat(5'h16, 1'b1);
    check("s5_count", 32'(count), 32'd1);
    check("s5_done",  32'(done),  32'd1);
`ifdef LED_PATTERN_WRITER_CHECKSUM_EN
    check("s5_checksum", 32'(checksum), 32'h16);
`endif
    read_check("s5_addr0", 4'd0, 5'h16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
